// File: rtl/multu_seq_unit.sv
// Iterative shift-add multiplier with architectural HI/LO registers (MULTU/MFHI/MFLO/MTHI/MTLO).
// Define MULTU_SEQ_SIGNED_EN to add signed MULT support through is_signed.
module multu_seq_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             is_signed,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [1:0]       dbg_state
);

  // Handshake: start is accepted only on an edge where busy=0; while busy=1 the
  // controller stalls, start and hi_we/lo_we are ignored, and done marks the HI/LO update.

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  logic [1:0]         state;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   a_in;
  logic [WIDTH-1:0]   b_in;
  logic [2*WIDTH-1:0] result;
  logic               sign_in;
  logic               sign;

`ifdef MULTU_SEQ_SIGNED_EN
  // Magnitudes go through the unsigned datapath; the sign is reapplied at FIN.
  always_comb begin
    a_in    = (is_signed && op_a[WIDTH-1]) ? (WIDTH'(0) - op_a) : op_a;
    b_in    = (is_signed && op_b[WIDTH-1]) ? (WIDTH'(0) - op_b) : op_b;
    sign_in = is_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
  end
`else
  logic unused_is_signed;
  assign unused_is_signed = is_signed;
  always_comb begin
    a_in    = op_a;
    b_in    = op_b;
    sign_in = 1'b0;
  end
`endif

  assign result    = sign ? ((2*WIDTH)'(0) - acc) : acc;
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_FIN);
  assign dbg_state = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= S_IDLE;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      sign   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            mcand  <= {{WIDTH{1'b0}}, a_in};
            mplier <= b_in;
            sign   <= sign_in;
            acc    <= '0;
            cnt    <= '0;
            state  <= S_RUN;
          end else begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
          end
        end
        S_RUN: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) state <= S_FIN;
        end
        S_FIN: begin
          hi    <= result[2*WIDTH-1:WIDTH];
          lo    <= result[WIDTH-1:0];
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
